// File: rtl/spdif_rx.sv
// spdif_rx: IEC 60958 / S/PDIF receiver.
// Oversamples the biphase-mark line and classifies intervals between transitions.
// It decodes B/M/W preambles and 28-bit subframes, and delivers 24-bit stereo pairs
// on a valid/ready stream. It also reports lock, parity errors and output overruns.
// Optional feature: define SPDIF_RX_CSTAT_EN to add channel-status capture
// (cstat_o[39:0], cstat_valid_o) from the channel-A C bits of frames 0..39 of a block.
module spdif_rx #(
    parameter int UI_CLKS     = 8,
    parameter int LOCK_FRAMES = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        spdif_i,
    output logic [23:0] sample_l_o,
    output logic [23:0] sample_r_o,
    output logic        sample_valid_o,
    input  logic        sample_ready_i,
    output logic        block_start_o,
    output logic        locked_o,
    output logic        parity_err_o,
    output logic        overrun_o
`ifdef SPDIF_RX_CSTAT_EN
    ,
    output logic [39:0] cstat_o,
    output logic        cstat_valid_o
`endif
);

    // Interval thresholds in clk cycles; "< x.5 UI" rounded up so odd UI_CLKS still works.
    localparam int S_MAX = (3 * UI_CLKS + 1) / 2;
    localparam int M_MAX = (5 * UI_CLKS + 1) / 2;
    localparam int L_MAX = (7 * UI_CLKS + 1) / 2;
    localparam int SAT   = 4 * UI_CLKS;
    localparam int CW    = $clog2(SAT + 1);
    localparam int GW    = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {ST_HUNT, ST_PRE, ST_DATA} state_t;
    typedef enum logic [1:0] {PT_B, PT_M, PT_W} pre_t;
    typedef enum logic [1:0] {IV_S, IV_M, IV_L, IV_BAD} ival_t;

    logic          sync1, sync2, sync3;
    logic          line_edge;
    logic [CW-1:0] cnt;
    logic          idle_timeout;
    ival_t         ival;

    state_t        state, state_n;
    logic [1:0]    pre_step, pre_step_n;
    pre_t          pre_type, pre_type_n;
    logic          half_pend, half_n;
    logic [4:0]    bit_cnt, bit_cnt_n;
    logic [26:0]   shift;
    logic          bit_done, bit_val, line_err;

    logic [27:0]   sub_word;
    logic          sub_done, par_bad, is_left, seq_err, pair_done, any_err, lock_now, deliver;
    logic [23:0]   left_hold;
    logic          left_b, left_pend;
    logic [GW-1:0] good_cnt;

    // Two-stage synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= spdif_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign line_edge    = sync2 ^ sync3;
    assign idle_timeout = !line_edge && (cnt == CW'(SAT - 1));

    // Interval counter: restarts at each edge, saturates instead of wrapping on an idle line
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (line_edge) begin
            cnt <= CW'(1);
        end else if (cnt != CW'(SAT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Classify the interval that the current edge terminates
    always_comb begin
        ival = IV_BAD;
        if (cnt < CW'(S_MAX)) begin
            ival = IV_S;
        end else if (cnt < CW'(M_MAX)) begin
            ival = IV_M;
        end else if (cnt < CW'(L_MAX)) begin
            ival = IV_L;
        end
    end

    assign sub_word  = {bit_val, shift};
    assign sub_done  = bit_done && (bit_cnt == 5'd27);
    assign par_bad   = sub_done && (^sub_word);
    assign is_left   = (pre_type != PT_W);
    assign seq_err   = sub_done && !par_bad && (is_left == left_pend);
    assign pair_done = sub_done && !par_bad && !is_left && left_pend;
    assign any_err   = line_err || seq_err || par_bad;
    assign lock_now  = (good_cnt == GW'(LOCK_FRAMES - 1));
    assign deliver   = pair_done && (locked_o || lock_now);

    // Framing state register and bit shift register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= ST_HUNT;
            pre_step  <= 2'd0;
            pre_type  <= PT_B;
            half_pend <= 1'b0;
            bit_cnt   <= 5'd0;
            shift     <= '0;
        end else begin
            state     <= state_n;
            pre_step  <= pre_step_n;
            pre_type  <= pre_type_n;
            half_pend <= half_n;
            bit_cnt   <= bit_cnt_n;
            if (bit_done) begin
                shift <= sub_word[27:1];
            end
        end
    end

    // Framing next-state: preamble recognition and biphase-mark bit decoding
    always_comb begin
        state_n    = state;
        pre_step_n = pre_step;
        pre_type_n = pre_type;
        half_n     = half_pend;
        bit_cnt_n  = bit_cnt;
        bit_done   = 1'b0;
        bit_val    = 1'b0;
        line_err   = 1'b0;
        case (state)
            ST_HUNT: begin
                if (line_edge && ival == IV_L) begin
                    state_n    = ST_PRE;
                    pre_step_n = 2'd1;
                end
            end
            ST_PRE: begin
                if (idle_timeout) begin
                    line_err = 1'b1;
                end else if (line_edge) begin
                    case (pre_step)
                        2'd1: begin
                            pre_step_n = 2'd2;
                            case (ival)
                                IV_S:    pre_type_n = PT_B;
                                IV_L:    pre_type_n = PT_M;
                                IV_M:    pre_type_n = PT_W;
                                default: line_err   = 1'b1;
                            endcase
                        end
                        2'd2: begin
                            if (ival == IV_S) begin
                                pre_step_n = 2'd3;
                            end else begin
                                line_err = 1'b1;
                            end
                        end
                        default: begin
                            if ((pre_type == PT_B && ival == IV_L) ||
                                (pre_type == PT_M && ival == IV_S) ||
                                (pre_type == PT_W && ival == IV_M)) begin
                                state_n   = ST_DATA;
                                bit_cnt_n = 5'd0;
                                half_n    = 1'b0;
                            end else begin
                                line_err = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_DATA: begin
                if (idle_timeout) begin
                    line_err = 1'b1;
                end else if (line_edge) begin
                    if (bit_cnt == 5'd28) begin
                        if (ival == IV_L) begin
                            state_n    = ST_PRE;
                            pre_step_n = 2'd1;
                        end else begin
                            line_err = 1'b1;
                        end
                    end else if (half_pend) begin
                        if (ival == IV_S) begin
                            bit_done = 1'b1;
                            bit_val  = 1'b1;
                            half_n   = 1'b0;
                        end else begin
                            line_err = 1'b1;
                        end
                    end else begin
                        case (ival)
                            IV_M:    bit_done = 1'b1;
                            IV_S:    half_n   = 1'b1;
                            default: line_err = 1'b1;
                        endcase
                    end
                    if (bit_done) begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
            end
            default: state_n = ST_HUNT;
        endcase
        if (line_err || seq_err) begin
            state_n = ST_HUNT;
        end
    end

    // Channel pairing, parity reporting and lock qualification
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            left_hold    <= '0;
            left_b       <= 1'b0;
            left_pend    <= 1'b0;
            good_cnt     <= '0;
            locked_o     <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= par_bad;
            if (any_err) begin
                locked_o  <= 1'b0;
                good_cnt  <= '0;
                left_pend <= 1'b0;
            end else if (sub_done && is_left) begin
                left_hold <= sub_word[23:0];
                left_b    <= (pre_type == PT_B);
                left_pend <= 1'b1;
            end else if (pair_done) begin
                left_pend <= 1'b0;
                if (lock_now) begin
                    locked_o <= 1'b1;
                end else begin
                    good_cnt <= good_cnt + GW'(1);
                end
            end
        end
    end

    // Single-entry output register with overrun detection under backpressure
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sample_l_o     <= '0;
            sample_r_o     <= '0;
            block_start_o  <= 1'b0;
            sample_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (deliver) begin
                if (sample_valid_o && !sample_ready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    sample_l_o     <= left_hold;
                    sample_r_o     <= sub_word[23:0];
                    block_start_o  <= left_b;
                    sample_valid_o <= 1'b1;
                end
            end else if (sample_valid_o && sample_ready_i) begin
                sample_valid_o <= 1'b0;
            end
        end
    end

`ifdef SPDIF_RX_CSTAT_EN
    logic        cs_active;
    logic [5:0]  cs_idx;
    logic [39:0] cs_buf;
    logic        cs_cbit;

    // Channel-status collection: C bit of each left subframe, frames 0..39 after a B
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cs_active     <= 1'b0;
            cs_idx        <= 6'd0;
            cs_buf        <= '0;
            cs_cbit       <= 1'b0;
            cstat_o       <= '0;
            cstat_valid_o <= 1'b0;
        end else begin
            cstat_valid_o <= 1'b0;
            if (any_err) begin
                cs_active <= 1'b0;
            end else if (sub_done && is_left) begin
                cs_cbit <= sub_word[26];
                if (pre_type == PT_B) begin
                    cs_active <= 1'b1;
                    cs_idx    <= 6'd0;
                end
            end else if (pair_done && cs_active) begin
                cs_buf[cs_idx] <= cs_cbit;
                if (cs_idx == 6'd39) begin
                    cstat_o       <= {cs_cbit, cs_buf[38:0]};
                    cstat_valid_o <= 1'b1;
                    cs_active     <= 1'b0;
                end else begin
                    cs_idx <= cs_idx + 6'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spdif_rx.sv
// tb_spdif_rx: self-checking bench for spdif_rx.
// A biphase-mark transmitter model drives frames; expected pairs are queued when sent
// and compared when the receiver hands them over on the valid/ready stream.
module tb_spdif_rx;

    localparam int UI = 8;
    localparam logic [7:0] PRE_B = 8'b1001_1100;
    localparam logic [7:0] PRE_M = 8'b1001_0011;
    localparam logic [7:0] PRE_W = 8'b1001_0110;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        spdif_i = 1'b0;
    logic        sample_ready_i = 1'b1;
    logic [23:0] sample_l_o, sample_r_o;
    logic        sample_valid_o, block_start_o, locked_o, parity_err_o, overrun_o;
`ifdef SPDIF_RX_CSTAT_EN
    logic [39:0] cstat_o;
    logic        cstat_valid_o;
`endif

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        b;
    } pair_t;

    pair_t       exp_q[$];
    pair_t       mon_exp;
    int          checks = 0;
    int          failures = 0;
    int          overruns = 0;
    int          parity_errs = 0;
    int          cstat_pulses = 0;
    logic [39:0] cstat_seen = '0;

    int          now = 0;
    int          next_ui = 0;
    int          jit_prev = 0;
    bit          jitter_en = 1'b0;
    int          blk_pos = 0;
    int          blk_len = 192;
    logic [39:0] cpat = '0;

    always #5 clk_i = ~clk_i;

    spdif_rx #(.UI_CLKS(UI), .LOCK_FRAMES(4)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .spdif_i        (spdif_i),
        .sample_l_o     (sample_l_o),
        .sample_r_o     (sample_r_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .block_start_o  (block_start_o),
        .locked_o       (locked_o),
        .parity_err_o   (parity_err_o),
        .overrun_o      (overrun_o)
`ifdef SPDIF_RX_CSTAT_EN
        ,
        .cstat_o        (cstat_o),
        .cstat_valid_o  (cstat_valid_o)
`endif
    );

    // Output monitor: counts pulses and checks every handshaken pair against the queue
    always begin
        @(negedge clk_i);
        #1;
        if (rst_n_i) begin
            if (overrun_o) overruns++;
            if (parity_err_o) parity_errs++;
`ifdef SPDIF_RX_CSTAT_EN
            if (cstat_valid_o) begin
                cstat_pulses++;
                cstat_seen = cstat_o;
            end
`endif
            if (sample_valid_o && sample_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL pair_unexpected: got l=%h r=%h b=%b, required none", sample_l_o, sample_r_o, block_start_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({sample_l_o, sample_r_o, block_start_o} !== mon_exp) begin
                        failures++;
                        $display("[TB] FAIL pair_data: got l=%h r=%h b=%b, required l=%h r=%h b=%b", sample_l_o, sample_r_o, block_start_o, mon_exp.l, mon_exp.r, mon_exp.b);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk_i);
        now++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic toggle_at(input int nominal);
        int j;
        j = 0;
        if (jitter_en) begin
            j = int'($urandom_range(4, 0)) - 2;
            if (j - jit_prev > 3) j = jit_prev + 3;
            if (jit_prev - j > 3) j = jit_prev - 3;
        end
        jit_prev = j;
        while (now < nominal + j) tick();
        spdif_i = ~spdif_i;
    endtask

    task automatic send_ui(input logic tog);
        if (tog) toggle_at(next_ui);
        next_ui += UI;
    endtask

    task automatic start_stream();
        next_ui  = now + 4;
        jit_prev = 0;
        blk_pos  = 0;
    endtask

    function automatic logic [27:0] make_word(input logic [23:0] d, input logic c, input logic flip);
        logic p;
        p = ^{c, 1'b0, 1'b0, d} ^ flip;
        return {p, c, 1'b0, 1'b0, d};
    endfunction

    task automatic send_subframe(input logic [7:0] pre, input logic [27:0] w, input logic set_rdy, input logic rdy);
        for (int u = 0; u < 8; u++) begin
            send_ui(pre[7-u]);
            if (set_rdy && u == 3) sample_ready_i = rdy;
        end
        for (int k = 0; k < 28; k++) begin
            send_ui(1'b1);
            send_ui(w[k]);
        end
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input logic rdy, input logic expect_out, input logic flip_r);
        logic  is_b, c;
        pair_t p;
        is_b = (blk_pos == 0);
        c    = (blk_pos < 40) ? cpat[blk_pos] : 1'b0;
        send_subframe(is_b ? PRE_B : PRE_M, make_word(l, c, 1'b0), 1'b1, rdy);
        send_subframe(PRE_W, make_word(r, 1'b0, flip_r), 1'b0, 1'b0);
        if (expect_out) begin
            p.l = l;
            p.r = r;
            p.b = is_b;
            exp_q.push_back(p);
        end
        blk_pos = (blk_pos + 1 == blk_len) ? 0 : blk_pos + 1;
    endtask

    task automatic send_tail();
        toggle_at(next_ui);
        next_ui += UI;
        idle(10);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (4) begin
            tick();
            spdif_i = ~spdif_i;
        end
        checks++;
        if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, required 0", sample_valid_o); end
        checks++;
        if (locked_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked: got %b, required 0", locked_o); end
        checks++;
        if ({parity_err_o, overrun_o, block_start_o} !== 3'b000) begin failures++; $display("[TB] FAIL reset_pulses: got %b, required 000", {parity_err_o, overrun_o, block_start_o}); end
        checks++;
        if ({sample_l_o, sample_r_o} !== 48'h0) begin failures++; $display("[TB] FAIL reset_data: got %h, required 0", {sample_l_o, sample_r_o}); end
        rst_n_i = 1'b1;
        idle(80);
    endtask

    task automatic test_clean_stream();
        int perr0;
        perr0   = parity_errs;
        blk_len = 5;
        start_stream();
        for (int i = 0; i < 8; i++) begin
            send_pair(24'h123456, 24'hABCDEF, 1'b1, i >= 3, 1'b0);
            if (i == 3) begin
                checks++;
                if (locked_o !== 1'b0) begin failures++; $display("[TB] FAIL clean_prelock: got %b, required 0", locked_o); end
            end
            if (i == 4) begin
                checks++;
                if (locked_o !== 1'b1) begin failures++; $display("[TB] FAIL clean_lock: got %b, required 1", locked_o); end
            end
        end
        send_tail();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL clean_pending: got %0d pairs left, required 0", exp_q.size()); end
        checks++;
        if (parity_errs != perr0) begin failures++; $display("[TB] FAIL clean_parity: got %0d pulses, required 0", parity_errs - perr0); end
        idle(60);
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [23:0] bl[8];
        logic [23:0] br[8];
        int          ovr0;
        for (int i = 0; i < 8; i++) begin
            bl[i] = 24'($urandom);
            br[i] = 24'($urandom);
        end
        ovr0    = overruns;
        blk_len = 192;
        start_stream();
        for (int i = 0; i < 8; i++) begin
            send_pair(bl[i], br[i], !(i >= 4 && i <= 6), (i == 3 || i == 4 || i == 7), 1'b0);
            if (i == 6) begin
                checks++;
                if ({sample_valid_o, sample_l_o, sample_r_o} !== {1'b1, bl[4], br[4]}) begin
                    failures++;
                    $display("[TB] FAIL bp_hold: got v=%b l=%h r=%h, required v=1 l=%h r=%h", sample_valid_o, sample_l_o, sample_r_o, bl[4], br[4]);
                end
            end
        end
        send_tail();
        checks++;
        if (overruns - ovr0 != 2) begin failures++; $display("[TB] FAIL bp_overrun: got %0d pulses, required 2", overruns - ovr0); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL bp_pending: got %0d pairs left, required 0", exp_q.size()); end
        idle(60);
        exp_q.delete();
        sample_ready_i = 1'b1;
    endtask

    task automatic test_parity();
        int perr0;
        perr0   = parity_errs;
        blk_len = 192;
        start_stream();
        for (int i = 0; i < 9; i++) begin
            send_pair(24'($urandom), 24'($urandom), 1'b1, (i == 3 || i == 8), i == 4);
            if (i == 6) begin
                checks++;
                if (locked_o !== 1'b0) begin failures++; $display("[TB] FAIL parity_unlock: got %b, required 0", locked_o); end
            end
        end
        send_tail();
        checks++;
        if (parity_errs - perr0 != 1) begin failures++; $display("[TB] FAIL parity_pulse: got %0d pulses, required 1", parity_errs - perr0); end
        checks++;
        if (locked_o !== 1'b1) begin failures++; $display("[TB] FAIL parity_relock: got %b, required 1", locked_o); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL parity_pending: got %0d pairs left, required 0", exp_q.size()); end
        idle(60);
        exp_q.delete();
    endtask

    task automatic test_jitter_idle();
        int perr0;
        perr0     = parity_errs;
        blk_len   = 192;
        jitter_en = 1'b1;
        start_stream();
        for (int i = 0; i < 8; i++) begin
            send_pair(24'($urandom), 24'($urandom), 1'b1, i >= 3, 1'b0);
        end
        send_tail();
        jitter_en = 1'b0;
        checks++;
        if (locked_o !== 1'b1) begin failures++; $display("[TB] FAIL jitter_lock: got %b, required 1", locked_o); end
        checks++;
        if (parity_errs != perr0) begin failures++; $display("[TB] FAIL jitter_parity: got %0d pulses, required 0", parity_errs - perr0); end
        idle(40);
        checks++;
        if (locked_o !== 1'b0) begin failures++; $display("[TB] FAIL idle_unlock: got %b, required 0", locked_o); end
        start_stream();
        for (int i = 0; i < 4; i++) begin
            send_pair(24'($urandom), 24'($urandom), 1'b1, i == 3, 1'b0);
        end
        send_tail();
        checks++;
        if (locked_o !== 1'b1) begin failures++; $display("[TB] FAIL idle_relock: got %b, required 1", locked_o); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL jitter_pending: got %0d pairs left, required 0", exp_q.size()); end
        idle(60);
        exp_q.delete();
    endtask

`ifdef SPDIF_RX_CSTAT_EN
    task automatic test_cstat();
        int cs0;
        cs0     = cstat_pulses;
        cpat    = 40'h00_0200_0004;
        blk_len = 192;
        start_stream();
        for (int i = 0; i < 41; i++) begin
            send_pair(24'($urandom), 24'($urandom), 1'b1, i >= 3, 1'b0);
        end
        send_tail();
        checks++;
        if (cstat_pulses - cs0 != 1) begin failures++; $display("[TB] FAIL cstat_pulse: got %0d pulses, required 1", cstat_pulses - cs0); end
        checks++;
        if (cstat_seen !== cpat) begin failures++; $display("[TB] FAIL cstat_value: got %h, required %h", cstat_seen, cpat); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL cstat_pending: got %0d pairs left, required 0", exp_q.size()); end
        idle(60);
        exp_q.delete();
        cpat = '0;
    endtask
`endif

    // Scenario sequence
    initial begin
        test_reset();
        test_clean_stream();
        test_backpressure();
        test_parity();
        test_jitter_idle();
`ifdef SPDIF_RX_CSTAT_EN
        test_cstat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
